// File: rtl/half_mult_result_stage.sv
// half_mult_result_stage: registered output stage for the half-precision multiplier.
// Classifies each accepted product, buffers it with its tag in a DEPTH-entry FIFO
// and keeps sticky exception flags for software.
// Ports:
//   CLK, nRST                          clock, asynchronous active-low reset
//   in_valid/in_ready/in_product/in_tag producer handshake and product {s, e[4:0], m[9:0]}
//   out_valid/out_ready/out_result/out_tag/out_class  head entry, class one-hot {nan,inf,zero,sub,norm}
//   flush                              synchronous discard of all entries (wins over push/pop)
//   flags_clr                          synchronous clear of sticky_flags
//   sticky_flags                       {nan,inf,zero,sub} accumulated over accepted products
//   count                              occupied entries
module half_mult_result_stage #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_product,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_result,
    output logic [TAG_W-1:0]           out_tag,
    output logic [4:0]                 out_class,
    input  logic                       flush,
    input  logic                       flags_clr,
    output logic [3:0]                 sticky_flags,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [3:0]       sticky_q, sticky_d;
    logic [15:0]      res_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [4:0]       cls_q [DEPTH];
    logic [4:0]       in_class;
    logic             push, pop, e_ones, e_zero, m_zero;

    assign e_ones = &in_product[14:10];
    assign e_zero = ~|in_product[14:10];
    assign m_zero = ~|in_product[9:0];
    assign in_class = {e_ones & ~m_zero, e_ones & m_zero, e_zero & m_zero,
                       e_zero & ~m_zero, ~e_ones & ~e_zero};

    assign in_ready  = count_q != CW'(DEPTH);
    assign out_valid = count_q != '0;
    // flush suppresses both handshakes so a product offered during flush is dropped
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
        count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
        sticky_d = flush ? sticky_q
                 : (flags_clr ? 4'b0 : sticky_q) | (push ? in_class[4:1] : 4'b0);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                res_q[i] <= '0;
                tag_q[i] <= '0;
                cls_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
            if (push) begin
                res_q[wr_ptr_q] <= in_product;
                tag_q[wr_ptr_q] <= in_tag;
                cls_q[wr_ptr_q] <= in_class;
            end
        end
    end

    assign out_result   = res_q[rd_ptr_q];
    assign out_tag      = tag_q[rd_ptr_q];
    assign out_class    = cls_q[rd_ptr_q];
    assign sticky_flags = sticky_q;
    assign count        = count_q;
endmodule

// File: tb/tb_half_mult_result_stage.sv
// tb_half_mult_result_stage: directed plus randomized checks against a queue-based reference model.
module tb_half_mult_result_stage;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             CLK = 0, nRST = 0;
    logic             in_valid = 0, in_ready, out_valid, out_ready = 0, flush = 0, flags_clr = 0;
    logic [15:0]      in_product = 0, out_result;
    logic [TAG_W-1:0] in_tag = 0, out_tag;
    logic [4:0]       out_class;
    logic [3:0]       sticky_flags;
    logic [2:0]       count;

    half_mult_result_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
        .in_product(in_product), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .out_class(out_class), .flush(flush), .flags_clr(flags_clr),
        .sticky_flags(sticky_flags), .count(count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0]      p;
        logic [TAG_W-1:0] t;
        logic [4:0]       c;
    } ent_t;

    ent_t q[$];
    logic [3:0] sticky_m = 0;
    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // class bits {nan,inf,zero,sub,norm} as values 16/8/4/2/1
    function automatic logic [4:0] ref_class(input logic [15:0] p);
        int e, m;
        e = (p / 1024) % 32;
        m = p % 1024;
        if (e == 31) return (m != 0) ? 5'd16 : 5'd8;
        if (e == 0)  return (m != 0) ? 5'd2 : 5'd4;
        return 5'd1;
    endfunction

    task automatic compare();
        check("count", 32'(count), 32'(q.size()));
        check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("sticky", 32'(sticky_flags), 32'(sticky_m));
        if (q.size() != 0) begin
            check("out_result", 32'(out_result), 32'(q[0].p));
            check("out_tag", 32'(out_tag), 32'(q[0].t));
            check("out_class", 32'(out_class), 32'(q[0].c));
        end
    endtask

    task automatic model_step();
        bit psh, pp;
        logic [4:0] c;
        psh = in_valid && q.size() < DEPTH;
        pp  = out_ready && q.size() > 0;
        c   = ref_class(in_product);
        if (flush) begin
            q.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (psh) q.push_back('{in_product, in_tag, c});
            if (flags_clr) sticky_m = 0;
            if (psh) sticky_m = sticky_m | c[4:1];
        end
    endtask

    // called #1 after a rising edge; leaves time at #1 after the next rising edge
    task automatic cyc(input logic v, input logic [15:0] p, input logic [TAG_W-1:0] t,
                       input logic ordy, input logic fl, input logic clr);
        in_valid = v; in_product = p; in_tag = t; out_ready = ordy; flush = fl; flags_clr = clr;
        compare();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] rand_prod();
        logic [15:0] p;
        p = 16'($urandom);
        case ($urandom_range(0, 5))
            0: p[14:10] = 5'h1F;
            1: p[14:10] = 5'h00;
            2: p[9:0] = '0;
            default: ;
        endcase
        if ($urandom_range(0, 7) == 0) p[9:0] = '0;
        return p;
    endfunction

    initial begin
        nRST = 0; in_valid = 1; in_product = 16'h3C00; in_tag = 3;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_sticky", 32'(sticky_flags), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_result", 32'(out_result), 0);
        nRST = 1;
        cyc(1, 16'h3C00, 3, 0, 0, 0);
        check("single_valid", 32'(out_valid), 1);
        check("single_result", 32'(out_result), 32'h3C00);
        check("single_tag", 32'(out_tag), 3);
        check("single_class", 32'(out_class), 32'b00001);
        check("single_sticky", 32'(sticky_flags), 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 16'h7C00, 1, 0, 0, 0);
        cyc(1, 16'h0000, 2, 0, 0, 0);
        cyc(1, 16'h0001, 3, 0, 0, 0);
        cyc(1, 16'hFFFF, 4, 0, 0, 0);
        check("full_count", 32'(count), 4);
        check("full_in_ready", 32'(in_ready), 0);
        check("full_sticky", 32'(sticky_flags), 32'b1111);
        check("head_inf", 32'(out_class), 32'b01000);
        cyc(1, 16'h3C00, 5, 1, 0, 0);
        check("full_pop_count", 32'(count), 3);
        check("head_zero", 32'(out_class), 32'b00100);
        cyc(1, 16'h4000, 6, 1, 0, 0);
        check("pushpop_count", 32'(count), 3);
        check("head_sub", 32'(out_class), 32'b00010);
        cyc(0, 0, 0, 1, 0, 0);
        check("head_nan", 32'(out_class), 32'b10000);
        repeat (3) cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 16'h7C00, 7, 0, 0, 1);
        check("sticky_inf", 32'(sticky_flags), 32'b0100);
        cyc(1, 16'h8000, 8, 0, 0, 1);
        check("clr_push", 32'(sticky_flags), 32'b0010);
        cyc(0, 0, 0, 0, 0, 1);
        check("clr_alone", 32'(sticky_flags), 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(1, 16'h3C00, 1, 0, 0, 0);
        cyc(1, 16'h4400, 2, 0, 0, 0);
        cyc(1, 16'hFDFF, 3, 0, 1, 0);
        check("flush_count", 32'(count), 0);
        check("flush_valid", 32'(out_valid), 0);
        check("flush_nan", 32'(sticky_flags[3]), 0);
        cyc(1, 16'h4000, 9, 0, 0, 0);
        check("post_flush_result", 32'(out_result), 32'h4000);
        check("post_flush_tag", 32'(out_tag), 9);
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) begin
                nRST = 0;
                #2;
                check("async_rst_count", 32'(count), 0);
                check("async_rst_valid", 32'(out_valid), 0);
                check("async_rst_sticky", 32'(sticky_flags), 0);
                q.delete();
                sticky_m = 0;
                #1 nRST = 1;
            end
            cyc(1'($urandom_range(0, 99) < ((i / 250) % 2 ? 75 : 40)), rand_prod(), TAG_W'($urandom),
                1'($urandom_range(0, 99) < ((i / 400) % 2 ? 30 : 70)),
                1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 15) == 0));
        end
        compare();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/half_mult_result_stage.md
Name: half_mult_result_stage

Overview:
- Registered output stage directly downstream of the combinational half-precision multiplier.
- Captures each 16-bit product with a tag under a valid/ready handshake and classifies it as NaN, Inf, zero, subnormal or normal.
- Buffers results in a DEPTH-entry FIFO for the writeback consumer.
- Keeps sticky exception flags that software reads and clears.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- TAG_W, 4, width of the opaque tag carried with each product.

Ports:
- CLK  input  1  clock.
- nRST  input  1  reset; asynchronous, active-low.
- in_valid  input  1  producer has a product this cycle.
- in_ready  output  1  stage can accept a product this cycle.
- in_product  input  16  product from the multiplier, as {sign, exp[4:0], mant[9:0]}.
- in_tag  input  TAG_W  tag associated with in_product.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_result  output  16  head product.
- out_tag  output  TAG_W  head tag.
- out_class  output  5  head classification, one-hot {nan, inf, zero, sub, norm}.
- flush  input  1  synchronous discard of all buffered entries.
- flags_clr  input  1  synchronous clear of the sticky flags.
- sticky_flags  output  4  {nan, inf, zero, sub}, OR of the classes of all accepted products since the last clear.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (nRST low, asynchronous):
  - read/write pointers, count, sticky_flags and all entry storage clear to 0;
  - therefore out_valid=0, out_result=0, out_tag=0, out_class=0, in_ready=1.
  - Reset asserted mid-operation discards every entry immediately.
- Handshake and ordering:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (count != DEPTH). It depends only on registered count and not on out_ready: no push into a full FIFO even when a pop occurs in the same cycle.
  - out_valid = (count != 0). out_result, out_tag and out_class come from the head entry register and are stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Order is strictly FIFO.
- Latency: a product accepted at edge k with the FIFO empty appears on out_* with out_valid=1 immediately after edge k. There is no combinational in-to-out path.
- Classification (computed from in_product at push, then stored; e=exp, m=mant):
  - nan: e==5'h1F and m!=0.
  - inf: e==5'h1F and m==0.
  - zero: e==0 and m==0, either sign.
  - sub: e==0 and m!=0.
  - norm: all other codes.
  - Exactly one bit is set per stored entry.
- Sticky flags:
  - On push, sticky_flags |= class[4:1].
  - flags_clr alone sets sticky_flags to 0 on the next edge.
  - flags_clr and push in the same cycle: sticky_flags becomes the class bits of the new product only.
  - flush does not affect sticky_flags.
- Flush:
  - On the next edge, count=0 and both pointers return to 0.
  - flush overrides push and pop in the same cycle: the pushed product is dropped and its class is NOT ORed into the flags.
  - in_ready is not lowered during flush.

Test Plan:
- Reset: hold nRST=0 with in_valid=1, then release → out_valid=0, count=0, sticky_flags=0, in_ready=1; the first edge after release accepts the product.
- Single product: push 0x3C00 (tag 3) into an empty FIFO → next cycle out_valid=1, out_result=0x3C00, out_tag=3, out_class=5'b00001, sticky_flags=0.
- Fill to full: push 0x7C00, 0x0000, 0x0001, 0xFFFF with out_ready=0.
  - Required: count=4 and in_ready=0.
  - Pop them in that order: out_class sequence is inf, zero, sub, nan.
  - sticky_flags=4'b1111.
- Full with simultaneous pop: FIFO full, in_valid=1 and out_ready=1 → one pop, the push is refused, count=3. Next cycle, push and pop together → count stays 3.
- Flags clear versus push: sticky=4'b0100. Assert flags_clr together with a push of 0x8000 → sticky=4'b0010. Then flags_clr alone → sticky=0.
- Flush: two entries stored, then flush with an in_valid push of 0xFDFF → count=0, out_valid=0, the nan flag stays clear, and the following push of 0x4000 appears at the head after one edge.
